// File: rtl/comp_pkg.sv
// comp_pkg: shared FSM state and result encodings for the bit-serial comparator
package comp_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;
endpackage

// File: rtl/comp_bit_cell.sv
// comp_bit_cell: one-bit magnitude compare, gt when x>y and lt when x<y
module comp_bit_cell (
  input  logic x,
  input  logic y,
  output logic gt,
  output logic lt
);
  assign gt = x & ~y;
  assign lt = ~x & y;
endmodule

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: MSB-first bit-serial magnitude comparator with registered gt/eq/lt and done pulse.
// Define EARLY_DECIDE_EN to finish on the first differing bit instead of always consuming WIDTH bits.
module serial_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic valid,
  input  logic x,
  input  logic y,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic decided_q, decided_d, sel_gt_q, sel_gt_d, done_q, done_d;
  logic [2:0] res_q, res_d;
  logic bit_gt, bit_lt, last, first_diff, finish;
  comp_bit_cell u_cell (.x(x), .y(y), .gt(bit_gt), .lt(bit_lt));
  assign last       = cnt_q == CW'(WIDTH - 1);
  assign first_diff = ~decided_q & (bit_gt | bit_lt);
`ifdef EARLY_DECIDE_EN
  assign finish = last | first_diff;
`else
  assign finish = last;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    sel_gt_d  = sel_gt_q;
    if (state_q == S_IDLE && start) begin
      state_d   = S_SHIFT;
      cnt_d     = '0;
      decided_d = 1'b0;
      sel_gt_d  = 1'b0;
    end else if (state_q == S_SHIFT && valid) begin
      decided_d = decided_q | first_diff;
      sel_gt_d  = first_diff ? bit_gt : sel_gt_q;
      cnt_d     = last ? cnt_q : cnt_q + 1'b1;
      state_d   = finish ? S_DONE : S_SHIFT;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
    done_d = (state_q == S_SHIFT) && (state_d == S_DONE);
    res_d  = !done_d ? res_q : !decided_d ? CMP_EQ : sel_gt_d ? CMP_GT : CMP_LT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      sel_gt_q  <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= CMP_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      sel_gt_q  <= sel_gt_d;
      done_q    <= done_d;
      res_q     <= res_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign {gt, eq, lt} = res_q;
endmodule
